// File: rtl/multicycle_main_control.sv
// -----------------------------------------------------------------------------
// multicycle_main_control
//
// Main control FSM for a multi-cycle MIPS datapath. Each instruction walks
// through FETCH, DECODE and then an opcode-specific execute / memory /
// write-back path before returning to FETCH. The block drives every datapath
// enable and mux select and the 2-bit ALUOp for the ALU control decoder.
//
// Memory handshake: mem_ready is a single-cycle completion flag from memory.
// In FETCH, MEMRD and MEMWR the FSM holds its state (and keeps its strobes
// asserted) until it samples mem_ready=1 on a rising clock edge; that edge
// completes the access. mem_ready is ignored in every other state.
//
// Ports:
//   clk          in   1  rising-edge clock
//   rst_n        in   1  asynchronous active-low reset (forces FETCH)
//   Op           in   6  opcode from the instruction register
//   mem_ready    in   1  memory completed the current access this cycle
//   PCWrite      out  1  unconditional PC write
//   PCWriteCond  out  1  PC write qualified by ALU zero (beq)
//   IorD         out  1  memory address select: 0=PC, 1=ALUOut
//   MemRead      out  1  memory read strobe
//   MemWrite     out  1  memory write strobe
//   MemtoReg     out  1  register write data: 0=ALUOut, 1=MDR
//   IRWrite      out  1  instruction register load
//   RegWrite     out  1  register file write
//   RegDst       out  1  destination register: 0=rt, 1=rd
//   ALUSrcA      out  1  ALU A select: 0=PC, 1=reg A
//   ALUSrcB      out  2  ALU B select: 00=B, 01=4, 10=imm, 11=imm<<2
//   PCSource     out  2  PC source: 00=ALU, 01=ALUOut, 10=jump target
//   ALUOp        out  2  00=add, 01=sub, 10=funct, 11=by Op (immediate)
//   illegal_op   out  1  pulse in DECODE for an unsupported opcode
//   dbg_state    out  4  current state code
// -----------------------------------------------------------------------------
module multicycle_main_control (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] Op,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       MemtoReg,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSource,
    output logic [1:0] ALUOp,
    output logic       illegal_op,
    output logic [3:0] dbg_state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_REX    = 4'd6,
        S_RWB    = 4'd7,
        S_BEQ    = 4'd8,
        S_JMP    = 4'd9,
        S_IEX    = 4'd10,
        S_IWB    = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_SLTI  = 6'b001010;

    state_t state_q;
    state_t state_d;

    // Opcode classification, shared by next-state and illegal_op decode.
    logic op_is_lw;
    logic op_is_sw;
    logic op_is_rtype;
    logic op_is_beq;
    logic op_is_j;
    logic op_is_imm;
    logic op_legal;

    always_comb begin
        op_is_lw    = (Op == OP_LW);
        op_is_sw    = (Op == OP_SW);
        op_is_rtype = (Op == OP_RTYPE);
        op_is_beq   = (Op == OP_BEQ);
        op_is_j     = (Op == OP_J);
        op_is_imm   = (Op == OP_ADDI) || (Op == OP_ANDI) || (Op == OP_ORI) ||
                      (Op == OP_XORI) || (Op == OP_SLTI);
        op_legal    = op_is_lw || op_is_sw || op_is_rtype || op_is_beq ||
                      op_is_j || op_is_imm;
    end

    // State register. Reset is asynchronous so an in-flight write-back or
    // memory write is cut off the moment rst_n falls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH: begin
                state_d = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                if (op_is_lw || op_is_sw) begin
                    state_d = S_MEMADR;
                end else if (op_is_rtype) begin
                    state_d = S_REX;
                end else if (op_is_beq) begin
                    state_d = S_BEQ;
                end else if (op_is_j) begin
                    state_d = S_JMP;
                end else if (op_is_imm) begin
                    state_d = S_IEX;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_MEMADR: begin
                // Op is held by the IR, so it is still lw or sw here; any
                // other value can only come from a corrupted IR.
                if (op_is_lw) begin
                    state_d = S_MEMRD;
                end else if (op_is_sw) begin
                    state_d = S_MEMWR;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_MEMRD: begin
                state_d = mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: state_d = S_FETCH;
            S_MEMWR: begin
                state_d = mem_ready ? S_FETCH : S_MEMWR;
            end
            S_REX:   state_d = S_RWB;
            S_RWB:   state_d = S_FETCH;
            S_BEQ:   state_d = S_FETCH;
            S_JMP:   state_d = S_FETCH;
            S_IEX:   state_d = S_IWB;
            S_IWB:   state_d = S_FETCH;
            // Codes 12-15 are unreachable; recover to FETCH.
            default: state_d = S_FETCH;
        endcase
    end

    // Output decode. Everything is Moore on state_q except the FETCH strobes
    // (which must only fire on the cycle memory delivers the instruction)
    // and illegal_op.
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        MemtoReg    = 1'b0;
        IRWrite     = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        PCSource    = 2'b00;
        ALUOp       = 2'b00;
        illegal_op  = 1'b0;
        case (state_q)
            S_FETCH: begin
                // PC + 4 is computed every FETCH cycle but only committed
                // (together with the IR load) when the read completes.
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            S_DECODE: begin
                // Speculatively compute the branch target into ALUOut.
                ALUSrcB    = 2'b11;
                illegal_op = ~op_legal;
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            S_MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            S_REX: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
            end
            S_RWB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            S_BEQ: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
            end
            S_JMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
            end
            S_IEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ALUOp   = 2'b11;
            end
            S_IWB: begin
                RegWrite = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign dbg_state = state_q;

endmodule

// File: tb/tb_multicycle_main_control.sv
// -----------------------------------------------------------------------------
// tb_multicycle_main_control
//
// Self-checking bench for multicycle_main_control. The driver walks each
// instruction along the state path implied by its opcode class, inserting
// random memory stalls, and for every cycle pushes the expected control
// vector into exp_q. A monitor on the falling edge pops and compares.
// -----------------------------------------------------------------------------
module tb_multicycle_main_control;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [5:0] Op = 6'd0;
    logic       mem_ready = 1'b0;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg;
    logic       IRWrite, RegWrite, RegDst, ALUSrcA;
    logic [1:0] ALUSrcB, PCSource, ALUOp;
    logic       illegal_op;
    logic [3:0] dbg_state;

    multicycle_main_control dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .Op         (Op),
        .mem_ready  (mem_ready),
        .PCWrite    (PCWrite),
        .PCWriteCond(PCWriteCond),
        .IorD       (IorD),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .MemtoReg   (MemtoReg),
        .IRWrite    (IRWrite),
        .RegWrite   (RegWrite),
        .RegDst     (RegDst),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .PCSource   (PCSource),
        .ALUOp      (ALUOp),
        .illegal_op (illegal_op),
        .dbg_state  (dbg_state)
    );

    // clock
    always #5 clk = ~clk;

    // Vector layout: {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,MemtoReg,
    //   IRWrite,RegWrite,RegDst,ALUSrcA,ALUSrcB,PCSource,ALUOp,illegal_op,state}
    localparam int W = 21;

    logic [W-1:0] exp_q[$];
    int total = 0;
    int bad = 0;
    int cyc = 0;

    logic [5:0] legal_ops [10] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
                                   6'b000010, 6'b001000, 6'b001100, 6'b001101,
                                   6'b001110, 6'b001010};

    function automatic bit is_legal(input logic [5:0] op);
        for (int i = 0; i < 10; i++) if (legal_ops[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    // Expected controls for a given state code, mem_ready and opcode.
    function automatic logic [W-1:0] model_out(input int st, input logic mr,
                                               input logic [5:0] op);
        logic pcw, pcwc, iord, mrd, mwr, m2r, irw, rw, rdst, asa, ill;
        logic [1:0] asb, pcs, aop;
        logic [3:0] s4;
        {pcw, pcwc, iord, mrd, mwr, m2r, irw, rw, rdst, asa, ill} = '0;
        asb = 2'd0; pcs = 2'd0; aop = 2'd0;
        s4 = 4'(st);
        case (st)
            0:  begin mrd = 1; asb = 2'd1; irw = mr; pcw = mr; end
            1:  begin asb = 2'd3; ill = !is_legal(op); end
            2:  begin asa = 1; asb = 2'd2; end
            3:  begin mrd = 1; iord = 1; end
            4:  begin rw = 1; m2r = 1; end
            5:  begin mwr = 1; iord = 1; end
            6:  begin asa = 1; aop = 2'd2; end
            7:  begin rw = 1; rdst = 1; end
            8:  begin asa = 1; aop = 2'd1; pcwc = 1; pcs = 2'd1; end
            9:  begin pcw = 1; pcs = 2'd2; end
            10: begin asa = 1; asb = 2'd2; aop = 2'd3; end
            11: begin rw = 1; end
            default: begin end
        endcase
        return {pcw, pcwc, iord, mrd, mwr, m2r, irw, rw, rdst, asa,
                asb, pcs, aop, ill, s4};
    endfunction

    // driver tasks
    task automatic step(input int st, input logic mr, input logic [5:0] op,
                        input logic rst_in);
        @(posedge clk);
        #1;
        rst_n = rst_in;
        mem_ready = mr;
        Op = op;
        exp_q.push_back(model_out(st, mr, op));
    endtask

    // Cycle in which reset falls part-way through; state must drop at once.
    task automatic abort_step(input logic mr, input logic [5:0] op);
        @(posedge clk);
        #1;
        mem_ready = mr;
        Op = op;
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (dbg_state !== 4'd0 || RegWrite !== 1'b0 || MemWrite !== 1'b0) begin
            bad++;
            $display("FAIL async_reset: got state=%0d RegWrite=%b MemWrite=%b, expected state=0 RegWrite=0 MemWrite=0",
                     dbg_state, RegWrite, MemWrite);
        end
        exp_q.push_back(model_out(0, mr, op));
    endtask

    task automatic run_instr(input logic [5:0] op, input int fs, input int ms,
                             input int abort_st);
        int path[$];
        for (int i = 0; i < fs; i++) step(0, 1'b0, 6'($urandom), 1'b1);
        step(0, 1'b1, op, 1'b1);
        path.push_back(1);
        case (op)
            6'b100011: begin path.push_back(2); path.push_back(3); path.push_back(4); end
            6'b101011: begin path.push_back(2); path.push_back(5); end
            6'b000000: begin path.push_back(6); path.push_back(7); end
            6'b000100: path.push_back(8);
            6'b000010: path.push_back(9);
            default: if (is_legal(op)) begin path.push_back(10); path.push_back(11); end
        endcase
        foreach (path[k]) begin
            if (path[k] == abort_st) begin
                abort_step(1'($urandom_range(0, 1)), op);
                return;
            end
            if (path[k] == 3 || path[k] == 5) begin
                for (int i = 0; i < ms; i++) step(path[k], 1'b0, op, 1'b1);
                step(path[k], 1'b1, op, 1'b1);
            end else begin
                step(path[k], 1'($urandom_range(0, 1)), op, 1'b1);
            end
        end
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        logic [W-1:0] e, a;
        cyc++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg,
                 IRWrite, RegWrite, RegDst, ALUSrcA, ALUSrcB, PCSource,
                 ALUOp, illegal_op, dbg_state};
            total++;
            if (a !== e) begin
                bad++;
                $display("FAIL ctl_vec cycle=%0d: got %h (state %0d) expected %h (state %0d)",
                         cyc, a, a[3:0], e, e[3:0]);
            end
        end
    end

    initial begin
        logic [5:0] op;
        #2;
        rst_n = 1'b0;
        // reset with mem_ready low, then high while still in reset
        step(0, 1'b0, 6'd0, 1'b0);
        step(0, 1'b1, 6'd0, 1'b0);
        // directed instructions
        run_instr(6'b000000, 1, 0, -1);
        run_instr(6'b100011, 0, 2, -1);
        run_instr(6'b101011, 0, 0, -1);
        run_instr(6'b101011, 1, 3, -1);
        run_instr(6'b000100, 0, 0, -1);
        run_instr(6'b001101, 0, 0, -1);
        run_instr(6'b000010, 0, 0, -1);
        run_instr(6'b111111, 0, 0, -1);
        run_instr(6'b000000, 0, 0, 7);
        run_instr(6'b100011, 0, 1, 4);
        // random instructions
        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 4) == 0) begin
                do op = 6'($urandom); while (is_legal(op));
            end else begin
                op = legal_ops[$urandom_range(0, 9)];
            end
            run_instr(op, $urandom_range(0, 2), $urandom_range(0, 3),
                      ($urandom_range(0, 9) == 0) ? $urandom_range(1, 11) : -1);
        end
        repeat (2) @(negedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL queue_drain: got %0d entries left, expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_main_control.md
# multicycle_main_control

Main control FSM for the multi-cycle MIPS datapath. It sequences each instruction through fetch, decode, execute, memory and write-back states. It drives every datapath enable and mux select, and generates the 2-bit `ALUOp` consumed by the ALU control decoder. It sits between the instruction register (which supplies `Op`) and the datapath. It handles memory wait states through a `mem_ready` handshake.

## Interface
Parameters:
- None. Opcode values and state codes are fixed constants, listed below.

Ports:
- `clk`  input  1  system clock, rising-edge.
- `rst_n`  input  1  reset, asynchronous, active-low.
- `Op`  input  6  opcode field from the instruction register. Sampled in DECODE.
- `mem_ready`  input  1  memory has completed the current read or write this cycle.
- `PCWrite`, `PCWriteCond`, `IorD`, `MemRead`, `MemWrite`, `MemtoReg`, `IRWrite`, `RegWrite`, `RegDst`, `ALUSrcA`  output  1 each  datapath controls.
- `ALUSrcB`  output  2  ALU B select: 00=reg B, 01=const 4, 10=sign-extended immediate, 11=sign-extended immediate<<2.
- `PCSource`  output  2  PC select: 00=ALU result, 01=ALUOut, 10=jump target.
- `ALUOp`  output  2  00=add, 01=sub, 10=decode by funct, 11=decode by Op (immediate).
- `illegal_op`  output  1  one-cycle pulse when DECODE sees an unsupported opcode.
- `dbg_state`  output  4  current state code.

## Operation
- Supported opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, j 000010, addi 001000, andi 001100, ori 001101, xori 001110, slti 001010.
- State codes: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, REX=6, RWB=7, BEQ=8, JMP=9, IEX=10, IWB=11. Codes 12–15 are unreachable; if entered, the next state is FETCH.
- FETCH: `MemRead`=1, `IorD`=0, `ALUSrcA`=0, `ALUSrcB`=01, `ALUOp`=00, `PCSource`=00.
  - `IRWrite`=`PCWrite`=`mem_ready`.
  - Go to DECODE when `mem_ready`=1; otherwise stay in FETCH.
- DECODE: `ALUSrcA`=0, `ALUSrcB`=11, `ALUOp`=00 (branch target into ALUOut). Next state by `Op`:
  - lw or sw → MEMADR
  - R-type → REX
  - beq → BEQ
  - j → JMP
  - addi, andi, ori, xori, slti → IEX
  - any other opcode → FETCH, with `illegal_op`=1 for this cycle only.
- MEMADR: `ALUSrcA`=1, `ALUSrcB`=10, `ALUOp`=00. Go to MEMRD for lw, MEMWR for sw.
- MEMRD: `MemRead`=1, `IorD`=1. Go to MEMWB when `mem_ready`=1; otherwise stay.
- MEMWB: `RegWrite`=1, `MemtoReg`=1, `RegDst`=0. Go to FETCH.
- MEMWR: `MemWrite`=1, `IorD`=1. Go to FETCH when `mem_ready`=1; otherwise stay.
- REX: `ALUSrcA`=1, `ALUSrcB`=00, `ALUOp`=10. Go to RWB.
- RWB: `RegWrite`=1, `RegDst`=1, `MemtoReg`=0. Go to FETCH.
- BEQ: `ALUSrcA`=1, `ALUSrcB`=00, `ALUOp`=01, `PCWriteCond`=1, `PCSource`=01. Go to FETCH.
- JMP: `PCWrite`=1, `PCSource`=10. Go to FETCH.
- IEX: `ALUSrcA`=1, `ALUSrcB`=10, `ALUOp`=11. Go to IWB.
- IWB: `RegWrite`=1, `RegDst`=0, `MemtoReg`=0. Go to FETCH.
- Any control not listed for a state is 0 in that state.
- `Op` is only decoded in DECODE and MEMADR. It is held stable by the IR, which is written only in FETCH.

## Timing
- Reset: `rst_n` low forces state to FETCH immediately, asynchronously. While in reset, outputs take FETCH values:
  - `MemRead`=1, `ALUSrcB`=01
  - `IRWrite`=`PCWrite`=`mem_ready`
  - every other output 0, including `illegal_op`=0 and `dbg_state`=0.
- A reset asserted mid-instruction aborts it. A write-back or memory-write state in progress when reset asserts produces no further strobes.
- All outputs are Moore outputs of the registered state, except `IRWrite`/`PCWrite` in FETCH (gated by `mem_ready`) and `illegal_op` (decoded from DECODE and `Op`). All outputs settle combinationally within the cycle.
- Cycle counts with `mem_ready` held at 1:
  - lw = 5
  - sw, R-type, immediate ops = 4
  - beq, j = 3
  - illegal opcode = 2
- Each cycle of `mem_ready`=0 in FETCH, MEMRD or MEMWR adds one cycle. Outputs hold steady and the strobes stay asserted during the stall.
- `mem_ready` is ignored in all other states.

## Test plan
- Reset with `mem_ready`=0 → `dbg_state`=0, `MemRead`=1, `ALUSrcB`=01, `PCWrite`=`IRWrite`=0. Raise `mem_ready` → `PCWrite`=`IRWrite`=1 in the same cycle, and DECODE on the next edge.
- `Op`=000000, `mem_ready`=1 → states 0,1,6,7,0. `ALUOp`=10 in state 6. `RegWrite`=`RegDst`=1 only in state 7.
- `Op`=100011 with `mem_ready` low for 2 cycles in MEMRD → states 0,1,2,3,3,3,4,0. `IorD`=1 throughout state 3. `MemtoReg`=`RegWrite`=1 in state 4.
- `Op`=101011 → states 0,1,2,5,0 with `MemWrite`=1 only in state 5. `Op`=000100 → 0,1,8,0 with `ALUOp`=01, `PCWriteCond`=1, `PCSource`=01 in state 8.
- `Op`=001101 → 0,1,10,11,0 with `ALUOp`=11 and `ALUSrcB`=10 in state 10. `Op`=000010 → 0,1,9,0 with `PCWrite`=1 and `PCSource`=10 in state 9.
- `Op`=111111 → `illegal_op`=1 for exactly one cycle in state 1, then state 0 with no `RegWrite`/`MemWrite`. Separately, assert `rst_n`=0 during state 7 → state 0 at once and `RegWrite`=0 at once.
